output_port_scheduler: RTL and testbench

OUTPUT_PORT_SCHEDULER -- requirements
Module: output_port_scheduler

---
 rtl/output_port_scheduler.sv | 144 ++++++++++++++
 tb/tb_output_port_scheduler.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/output_port_scheduler.sv
// -----------------------------------------------------------------------------
// output_port_scheduler
//
// Credit-based, packet-aware round-robin arbiter for one router output port.
// Five requesters compete for the port: NORTH, SOUTH, EAST, WEST and the
// cache read-return path. Once a multi-flit packet starts, the port stays
// locked to its owner until the flit marked "last" has gone. A flit moves
// only while the downstream buffer has a free slot, as shown by the credit
// counter.
//
// Parameters
//   CREDIT_MAX    downstream buffer slots; must equal the router's BUFFER_SIZE
//   CREDIT_WIDTH  width of the credit counter; must be able to hold CREDIT_MAX
//
// Ports
//   clk           rising-edge clock for all state
//   reset         asynchronous active-low reset; the instantiating top
//                 synchronises its deassertion
//   req[4:0]      per-requester request (0 N, 1 S, 2 E, 3 W, 4 cache return)
//   last[4:0]     per-requester end-of-packet flag, qualified by req
//   creditReturn  downstream freed one buffer slot this cycle
//   grant[4:0]    one-hot grant, combinational from registered state and req
//   transfer      a flit moves on the next rising edge
//   credits       registered count of free downstream slots
//   locked        registered; a packet is in progress and owner is fixed
//   owner[2:0]    registered index of the locked or last-granted requester
//   creditError   sticky flag; a credit was returned while already full
// -----------------------------------------------------------------------------
module output_port_scheduler #(
    parameter int CREDIT_MAX   = 8,
    parameter int CREDIT_WIDTH = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [4:0]              req,
    input  logic [4:0]              last,
    input  logic                    creditReturn,
    output logic [4:0]              grant,
    output logic                    transfer,
    output logic [CREDIT_WIDTH-1:0] credits,
    output logic                    locked,
    output logic [2:0]              owner,
    output logic                    creditError
);

    localparam int                      NumReq     = 5;
    localparam logic [CREDIT_WIDTH-1:0] CreditFull = CREDIT_WIDTH'(CREDIT_MAX);

    // Packet state: open for round-robin arbitration, or locked to owner.
    typedef enum logic {
        stOpen   = 1'b0,
        stLocked = 1'b1
    } lockState_t;

    lockState_t              stateReg;
    logic [2:0]              ptrReg;
    logic [2:0]              ownerReg;
    logic [CREDIT_WIDTH-1:0] creditsReg;
    logic                    creditErrorReg;

    // Round-robin scan results.
    logic       scanFound;
    logic [2:0] scanIdx;
    logic [3:0] scanPos;

    // Arbitration results.
    logic [NumReq-1:0] ownerHit;
    logic [2:0]        grantIdx;
    logic              grantValid;
    logic              hasCredit;

    // Decode which requester is the current owner and still requesting.
    genvar gi;
    generate
        for (gi = 0; gi < NumReq; gi++) begin : g_ownerHit
            assign ownerHit[gi] = (ownerReg == 3'(gi)) && req[gi];
        end
    endgenerate

    // Find the first set request at or after ptr, wrapping 4 -> 0.
    always_comb begin
        scanFound = 1'b0;
        scanIdx   = ptrReg;
        scanPos   = 4'd0;
        for (int off = 0; off < NumReq; off++) begin
            scanPos = {1'b0, ptrReg} + 4'(off);
            if (scanPos >= 4'(NumReq)) begin
                scanPos = scanPos - 4'(NumReq);
            end
            if (!scanFound && req[scanPos[2:0]]) begin
                scanFound = 1'b1;
                scanIdx   = scanPos[2:0];
            end
        end
    end

    // The credit check uses the registered count only, so a creditReturn
    // arriving while empty cannot enable a grant in the same cycle. The reset
    // term forces grant low for as long as reset is held.
    assign hasCredit  = (creditsReg != '0);
    assign grantIdx   = (stateReg == stLocked) ? ownerReg : scanIdx;
    assign grantValid = reset && hasCredit &&
                        ((stateReg == stLocked) ? (|ownerHit) : scanFound);
    assign grant      = grantValid ? (5'b00001 << grantIdx) : 5'b00000;
    assign transfer   = |(grant & req);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stateReg       <= stOpen;
            ptrReg         <= 3'd0;
            ownerReg       <= 3'd0;
            creditsReg     <= CreditFull;
            creditErrorReg <= 1'b0;
        end else begin
            if (transfer) begin
                ptrReg   <= (grantIdx == 3'(NumReq - 1)) ? 3'd0 : grantIdx + 3'd1;
                ownerReg <= grantIdx;
                // A flit without "last" opens or continues a packet; the
                // closing flit (or a single-flit packet) leaves the port open.
                stateReg <= last[grantIdx] ? stOpen : stLocked;
            end

            // A transfer together with a return cancels out, even when full,
            // so only a lone return at full count is an overflow.
            unique case ({transfer, creditReturn})
                2'b10: creditsReg <= creditsReg - 1'b1;
                2'b01: begin
                    if (creditsReg == CreditFull) begin
                        creditErrorReg <= 1'b1;
                    end else begin
                        creditsReg <= creditsReg + 1'b1;
                    end
                end
                default: creditsReg <= creditsReg;
            endcase
        end
    end

    assign credits     = creditsReg;
    assign locked      = (stateReg == stLocked);
    assign owner       = ownerReg;
    assign creditError = creditErrorReg;

endmodule

// File: tb/tb_output_port_scheduler.sv
// -----------------------------------------------------------------------------
// tb_output_port_scheduler
//
// Directed scenarios for output_port_scheduler. Each step drives one cycle of
// inputs, checks the combinational grant within that cycle, and queues the
// registered state expected after the following rising edge. A monitor pops
// that expectation and compares it just after the edge.
// -----------------------------------------------------------------------------
module tb_output_port_scheduler;

    logic       clk;
    logic       reset;
    logic [4:0] req;
    logic [4:0] last;
    logic       creditReturn;
    logic [4:0] grant;
    logic       transfer;
    logic [3:0] credits;
    logic       locked;
    logic [2:0] owner;
    logic       creditError;

    int assertCount = 0;
    int failCount   = 0;

    typedef struct {
        int   credits;
        logic locked;
        logic creditError;
        int   owner;
    } expState_t;

    expState_t stateQ[$];

    output_port_scheduler #(
        .CREDIT_MAX  (8),
        .CREDIT_WIDTH(4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req         (req),
        .last        (last),
        .creditReturn(creditReturn),
        .grant       (grant),
        .transfer    (transfer),
        .credits     (credits),
        .locked      (locked),
        .owner       (owner),
        .creditError (creditError)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        assertCount++;
        if (obs !== exp) begin
            failCount++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Registered-state scoreboard: pops one expectation per rising edge.
    always @(posedge clk) begin
        #1;
        if (stateQ.size() > 0) begin
            expState_t e;
            e = stateQ.pop_front();
            checkVal("credits", 32'(credits), 32'(e.credits));
            checkVal("locked", 32'(locked), 32'(e.locked));
            checkVal("creditError", 32'(creditError), 32'(e.creditError));
            checkVal("owner", 32'(owner), 32'(e.owner));
            $display("t=%0t state credits=%0d locked=%0b err=%0b owner=%0d",
                     $time, credits, locked, creditError, owner);
        end
    end

    // One cycle: drive inputs, check grant/transfer, queue post-edge state.
    task automatic step(input logic [4:0] r, input logic [4:0] l, input logic c,
                        input logic [4:0] expGrant, input int expCredits,
                        input logic expLocked, input logic expErr, input int expOwner);
        expState_t e;
        @(negedge clk);
        req          = r;
        last         = l;
        creditReturn = c;
        e.credits     = expCredits;
        e.locked      = expLocked;
        e.creditError = expErr;
        e.owner       = expOwner;
        stateQ.push_back(e);
        #1;
        checkVal("grant", 32'(grant), 32'(expGrant));
        checkVal("transfer", 32'(transfer), 32'(|expGrant));
        $display("t=%0t req=%b last=%b cr=%b grant=%b (exp %b)",
                 $time, r, l, c, grant, expGrant);
    endtask

    task automatic checkResetState(input string tag);
        checkVal({tag, "_grant"}, 32'(grant), 32'd0);
        checkVal({tag, "_transfer"}, 32'(transfer), 32'd0);
        checkVal({tag, "_credits"}, 32'(credits), 32'd8);
        checkVal({tag, "_locked"}, 32'(locked), 32'd0);
        checkVal({tag, "_owner"}, 32'(owner), 32'd0);
        checkVal({tag, "_creditError"}, 32'(creditError), 32'd0);
        $display("t=%0t reset check %s credits=%0d locked=%0b", $time, tag, credits, locked);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset held with every requester active: nothing may be granted.
        reset        = 1'b0;
        req          = 5'b11111;
        last         = 5'b11111;
        creditReturn = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        checkResetState("por");
        @(negedge clk);
        req   = 5'b00000;
        reset = 1'b1;

        // Round robin over all five single-flit requesters, NORTH first.
        step(5'b11111, 5'b11111, 1'b0, 5'b00001, 7, 1'b0, 1'b0, 0);
        step(5'b11111, 5'b11111, 1'b0, 5'b00010, 6, 1'b0, 1'b0, 1);
        step(5'b11111, 5'b11111, 1'b0, 5'b00100, 5, 1'b0, 1'b0, 2);
        step(5'b11111, 5'b11111, 1'b0, 5'b01000, 4, 1'b0, 1'b0, 3);
        step(5'b11111, 5'b11111, 1'b0, 5'b10000, 3, 1'b0, 1'b0, 4);

        // Transfer plus creditReturn at credits=3 leaves the count alone.
        step(5'b00001, 5'b11111, 1'b1, 5'b00001, 3, 1'b0, 1'b0, 0);

        // Refill to full with lone returns.
        for (int k = 4; k <= 8; k++) begin
            step(5'b00000, 5'b00000, 1'b1, 5'b00000, k, 1'b0, 1'b0, 0);
        end

        // Lone return at full: saturate and raise the sticky error.
        step(5'b00000, 5'b00000, 1'b1, 5'b00000, 8, 1'b0, 1'b1, 0);
        step(5'b00000, 5'b00000, 1'b0, 5'b00000, 8, 1'b0, 1'b1, 0);

        // Four-flit EAST packet with NORTH also requesting (ptr=1).
        step(5'b00101, 5'b11011, 1'b0, 5'b00100, 7, 1'b1, 1'b1, 2);
        step(5'b00101, 5'b11011, 1'b0, 5'b00100, 6, 1'b1, 1'b1, 2);
        step(5'b00101, 5'b11011, 1'b0, 5'b00100, 5, 1'b1, 1'b1, 2);
        step(5'b00101, 5'b11111, 1'b0, 5'b00100, 4, 1'b0, 1'b1, 2);
        step(5'b00101, 5'b11111, 1'b0, 5'b00001, 3, 1'b0, 1'b1, 0);

        // Lock on WEST, then WEST drops req: hold with no grant to NORTH.
        step(5'b01000, 5'b00000, 1'b0, 5'b01000, 2, 1'b1, 1'b1, 3);
        step(5'b00001, 5'b11111, 1'b0, 5'b00000, 2, 1'b1, 1'b1, 3);
        step(5'b00001, 5'b11111, 1'b0, 5'b00000, 2, 1'b1, 1'b1, 3);

        // Reset pulse mid-packet discards the lock and restores credits.
        @(negedge clk);
        req   = 5'b11111;
        reset = 1'b0;
        #1;
        checkResetState("midpkt");
        @(negedge clk);
        req   = 5'b00000;
        reset = 1'b1;

        // At full, transfer plus return: no error, count stays full.
        step(5'b11111, 5'b11111, 1'b1, 5'b00001, 8, 1'b0, 1'b0, 0);

        // Drain all credits with SOUTH single-flit packets.
        for (int k = 7; k >= 0; k--) begin
            step(5'b00010, 5'b11111, 1'b0, 5'b00010, k, 1'b0, 1'b0, 1);
        end

        // Empty: request held, nothing granted; a return alone does not help
        // in its own cycle, the grant resumes on the next one.
        step(5'b00010, 5'b11111, 1'b0, 5'b00000, 0, 1'b0, 1'b0, 1);
        step(5'b00010, 5'b11111, 1'b1, 5'b00000, 1, 1'b0, 1'b0, 1);
        step(5'b00010, 5'b11111, 1'b0, 5'b00010, 0, 1'b0, 1'b0, 1);

        @(negedge clk);
        req = 5'b00000;
        @(negedge clk);
        checkVal("scoreboard_drained", 32'(stateQ.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
